// File: rtl/gcd_seq_pkg.sv
// Shared types and defaults for the GCD job sequencer: FSM state encoding,
// the default operand-pair record and the default watchdog limit.
package gcd_seq_pkg;

    localparam int DEFAULT_DATA_WIDTH     = 8;
    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY   = 2'd1,
        ST_RESULT = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic [DEFAULT_DATA_WIDTH-1:0] a;
        logic [DEFAULT_DATA_WIDTH-1:0] b;
    } operand_pair_t;

endpackage

// File: rtl/gcd_seq_fifo.sv
// Small synchronous FIFO holding operand pairs for the sequencer.
// Registered occupancy count; full/empty come straight from that count, so a
// pop in the same cycle never frees a slot for a push while full. No
// fall-through: a pushed entry becomes visible at the head on the next cycle.
module gcd_seq_fifo
    import gcd_seq_pkg::*;
#(
    parameter type entry_t = operand_pair_t,
    parameter int  DEPTH   = 4
) (
    input  logic   clk_i,
    input  logic   reset_i,
    input  logic   push_i,
    input  entry_t push_data_i,
    input  logic   pop_i,
    output entry_t pop_data_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push;
    logic               do_pop;

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign pop_data_o = mem_q[rd_ptr_q];

    // Next-state for storage, pointers (wrap at power-of-two depth) and count
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Register FIFO state; reset empties the queue
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/gcd_job_sequencer.sv
// Feeds buffered operand pairs to the GCD core one job at a time and returns
// each result downstream with a wrapping job ID.
// Optional watchdog: define GCD_SEQ_TIMEOUT_EN to abort a job that stays in
// BUSY for TIMEOUT_CYCLES cycles; it then completes with res_err_o=1, data 0.
module gcd_job_sequencer
    import gcd_seq_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int FIFO_DEPTH     = 4,
    parameter int ID_WIDTH       = 4,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_a_i,
    input  logic [DATA_WIDTH-1:0] in_b_i,
    output logic                  gcd_enable_o,
    output logic [DATA_WIDTH-1:0] operand_a_o,
    output logic [DATA_WIDTH-1:0] operand_b_o,
    input  logic                  gcd_done_i,
    input  logic [DATA_WIDTH-1:0] gcd_result_i,
    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic [DATA_WIDTH-1:0] res_data_o,
    output logic [ID_WIDTH-1:0]   res_id_o,
    output logic                  res_err_o
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
    } pair_t;

    seq_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
    logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
    logic                  enable_q, enable_d;
    logic                  res_valid_q, res_valid_d;
    logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
    logic [ID_WIDTH-1:0]   res_id_q, res_id_d;
    logic [ID_WIDTH-1:0]   job_id_q, job_id_d;

`ifdef GCD_SEQ_TIMEOUT_EN
    localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TIMER_W-1:0]    timer_q, timer_d;
    logic                  res_err_q, res_err_d;
`endif

    pair_t                 in_pair;
    pair_t                 fifo_head;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;

    assign in_pair    = {in_a_i, in_b_i};
    assign in_ready_o = !fifo_full;
    assign fifo_push  = in_valid_i && in_ready_o;
    assign fifo_pop   = (state_q == ST_IDLE) && !fifo_empty;

    gcd_seq_fifo #(
        .entry_t (pair_t),
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .push_i      (fifo_push),
        .push_data_i (in_pair),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Job FSM next-state: launch from FIFO, wait for the core, hold the result
    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        enable_d    = enable_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        job_id_d    = job_id_q;
`ifdef GCD_SEQ_TIMEOUT_EN
        timer_d     = timer_q;
        res_err_d   = res_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    op_a_d   = fifo_head.a;
                    op_b_d   = fifo_head.b;
                    enable_d = 1'b1;
                    state_d  = ST_BUSY;
`ifdef GCD_SEQ_TIMEOUT_EN
                    timer_d  = '0;
`endif
                end
            end
            ST_BUSY: begin
                if (gcd_done_i) begin
                    res_data_d  = gcd_result_i;
                    res_id_d    = job_id_q;
                    res_valid_d = 1'b1;
                    enable_d    = 1'b0;
                    job_id_d    = job_id_q + ID_WIDTH'(1);
                    state_d     = ST_RESULT;
`ifdef GCD_SEQ_TIMEOUT_EN
                    res_err_d   = 1'b0;
                end else if (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                    res_data_d  = '0;
                    res_id_d    = job_id_q;
                    res_err_d   = 1'b1;
                    res_valid_d = 1'b1;
                    enable_d    = 1'b0;
                    job_id_d    = job_id_q + ID_WIDTH'(1);
                    state_d     = ST_RESULT;
                end else begin
                    timer_d     = timer_q + TIMER_W'(1);
`endif
                end
            end
            ST_RESULT: begin
                if (res_ready_i) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Register FSM state and all outputs; reset abandons any in-flight job
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            enable_q    <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
            job_id_q    <= '0;
`ifdef GCD_SEQ_TIMEOUT_EN
            timer_q     <= '0;
            res_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            enable_q    <= enable_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
            job_id_q    <= job_id_d;
`ifdef GCD_SEQ_TIMEOUT_EN
            timer_q     <= timer_d;
            res_err_q   <= res_err_d;
`endif
        end
    end

    assign gcd_enable_o = enable_q;
    assign operand_a_o  = op_a_q;
    assign operand_b_o  = op_b_q;
    assign res_valid_o  = res_valid_q;
    assign res_data_o   = res_data_q;
    assign res_id_o     = res_id_q;
`ifdef GCD_SEQ_TIMEOUT_EN
    assign res_err_o    = res_err_q;
`else
    assign res_err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Testbench for gcd_job_sequencer paired with a behavioural Euclid GCD core.
// Expected results are queued when jobs are pushed and compared as the
// sequencer hands them downstream.
module tb_gcd_job_sequencer;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       in_valid_i;
    logic       in_ready_o;
    logic [7:0] in_a_i;
    logic [7:0] in_b_i;
    logic       gcd_enable_o;
    logic [7:0] operand_a_o;
    logic [7:0] operand_b_o;
    logic       gcd_done_i;
    logic [7:0] gcd_result_i;
    logic       res_valid_o;
    logic       res_ready_i;
    logic [7:0] res_data_o;
    logic [3:0] res_id_o;
    logic       res_err_o;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic [3:0] id;
        logic       err;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] exp_id;
    vec_t       vecs[6];
    int         total = 0;
    int         bad = 0;
    int         results_seen = 0;

    // Behavioural core: loads operands on first enabled cycle, one Euclid step per cycle
    logic [7:0] core_a, core_b, core_res;
    logic       core_started, core_done, kill_done;

    always #5 clk_i = ~clk_i;

    gcd_job_sequencer #(
        .DATA_WIDTH     (8),
        .FIFO_DEPTH     (4),
        .ID_WIDTH       (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_a_i       (in_a_i),
        .in_b_i       (in_b_i),
        .gcd_enable_o (gcd_enable_o),
        .operand_a_o  (operand_a_o),
        .operand_b_o  (operand_b_o),
        .gcd_done_i   (gcd_done_i),
        .gcd_result_i (gcd_result_i),
        .res_valid_o  (res_valid_o),
        .res_ready_i  (res_ready_i),
        .res_data_o   (res_data_o),
        .res_id_o     (res_id_o),
        .res_err_o    (res_err_o)
    );

    // Core model state
    always @(posedge clk_i) begin
        if (reset_i || !gcd_enable_o) begin
            core_started <= 1'b0;
            core_done    <= 1'b0;
        end else if (!core_started) begin
            core_a       <= operand_a_o;
            core_b       <= operand_b_o;
            core_started <= 1'b1;
        end else if (!core_done) begin
            if (core_b == 8'd0) begin
                core_done <= 1'b1;
                core_res  <= core_a;
            end else begin
                core_a <= core_b;
                core_b <= core_a % core_b;
            end
        end
    end

    assign gcd_done_i   = core_done && !kill_done;
    assign gcd_result_i = core_res;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Result monitor: every downstream handshake is compared with the scoreboard head
    always @(negedge clk_i) begin
        exp_t e;
        if (!reset_i && res_valid_o && res_ready_i) begin
            results_seen++;
            checkOutput("sb_pending", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("res_data", int'(res_data_o), int'(e.data));
                checkOutput("res_id", int'(res_id_o), int'(e.id));
                checkOutput("res_err", int'(res_err_o), int'(e.err));
                checkOutput("enable_in_result", int'(gcd_enable_o), 0);
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                 input logic [7:0] exp_data, input logic exp_err);
        int n;
        n = 0;
        in_valid_i = 1'b1;
        in_a_i     = a;
        in_b_i     = b;
        while (!in_ready_o && n < 200) begin
            step();
            n++;
        end
        if (!in_ready_o) begin
            checkOutput("push_ready_timeout", int'(in_ready_o), 1);
        end else begin
            exp_q.push_back('{data: exp_data, id: exp_id, err: exp_err});
            exp_id = exp_id + 4'd1;
        end
        step();
        in_valid_i = 1'b0;
    endtask

    task automatic doReset();
        reset_i    = 1'b1;
        in_valid_i = 1'b0;
        exp_q.delete();
        exp_id     = 4'd0;
        repeat (2) step();
        reset_i = 1'b0;
    endtask

    task automatic waitDrain(input int max_cycles);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            step();
            n++;
        end
        step();
        checkOutput("drain_left", exp_q.size(), 0);
    endtask

    task automatic waitValid(input int max_cycles);
        int n;
        n = 0;
        while (!res_valid_o && n < max_cycles) begin
            step();
            n++;
        end
        checkOutput("res_valid_seen", int'(res_valid_o), 1);
    endtask

    // Global time limit so the bench can never hang
    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int n;
        int seen_before;
        vecs[0] = '{8'd12, 8'd18, 8'd6};
        vecs[1] = '{8'd48, 8'd36, 8'd12};
        vecs[2] = '{8'd7,  8'd5,  8'd1};
        vecs[3] = '{8'd9,  8'd3,  8'd3};
        vecs[4] = '{8'd20, 8'd8,  8'd4};
        vecs[5] = '{8'd15, 8'd25, 8'd5};
        kill_done   = 1'b0;
        res_ready_i = 1'b0;
        in_a_i      = 8'd0;
        in_b_i      = 8'd0;
        doReset();

        // Reset state
        checkOutput("rst_in_ready", int'(in_ready_o), 1);
        checkOutput("rst_enable", int'(gcd_enable_o), 0);
        checkOutput("rst_res_valid", int'(res_valid_o), 0);
        checkOutput("rst_res_data", int'(res_data_o), 0);
        checkOutput("rst_res_id", int'(res_id_o), 0);
        checkOutput("rst_res_err", int'(res_err_o), 0);
        checkOutput("rst_operand_a", int'(operand_a_o), 0);
        checkOutput("rst_operand_b", int'(operand_b_o), 0);

        // Single job with launch latency
        res_ready_i = 1'b1;
        applyStimulus(vecs[0].a, vecs[0].b, vecs[0].exp, 1'b0);
        checkOutput("lat_enable_e0", int'(gcd_enable_o), 0);
        step();
        checkOutput("lat_enable_e1", int'(gcd_enable_o), 1);
        checkOutput("lat_operand_a", int'(operand_a_o), 12);
        checkOutput("lat_operand_b", int'(operand_b_o), 18);
        waitDrain(100);
        checkOutput("single_enable_after", int'(gcd_enable_o), 0);

        // Backlog of five jobs under backpressure
        doReset();
        res_ready_i = 1'b0;
        for (int i = 1; i < 6; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0);
        end
        checkOutput("backlog_in_ready", int'(in_ready_o), 0);
        waitValid(100);
        for (int c = 0; c < 10; c++) begin
            checkOutput("bp_valid", int'(res_valid_o), 1);
            checkOutput("bp_data", int'(res_data_o), 12);
            checkOutput("bp_id", int'(res_id_o), 0);
            checkOutput("bp_enable", int'(gcd_enable_o), 0);
            step();
        end
        checkOutput("bp_in_ready", int'(in_ready_o), 0);
        res_ready_i = 1'b1;
        waitDrain(300);
        checkOutput("backlog_in_ready_after", int'(in_ready_o), 1);

        // Reset in the middle of a busy job with two queued behind it
        doReset();
        res_ready_i = 1'b1;
        applyStimulus(8'd200, 8'd3, 8'd1, 1'b0);
        applyStimulus(8'd12, 8'd18, 8'd6, 1'b0);
        applyStimulus(8'd48, 8'd36, 8'd12, 1'b0);
        checkOutput("mid_enable_before", int'(gcd_enable_o), 1);
        reset_i = 1'b1;
        exp_q.delete();
        exp_id = 4'd0;
        step();
        checkOutput("mid_enable", int'(gcd_enable_o), 0);
        checkOutput("mid_res_valid", int'(res_valid_o), 0);
        checkOutput("mid_in_ready", int'(in_ready_o), 1);
        reset_i = 1'b0;
        seen_before = results_seen;
        repeat (40) step();
        checkOutput("mid_no_stale", results_seen - seen_before, 0);

        // Seventeen jobs: IDs run 0..15 then wrap to 0
        doReset();
        res_ready_i = 1'b1;
        for (int k = 0; k < 17; k++) begin
            applyStimulus(8'((k + 1) * 2), 8'((k + 1) * 3), 8'(k + 1), 1'b0);
        end
        waitDrain(500);
        checkOutput("wrap_last_id", int'(res_id_o), 0);

`ifdef GCD_SEQ_TIMEOUT_EN
        // Watchdog abort followed by a normal job
        doReset();
        res_ready_i = 1'b0;
        kill_done   = 1'b1;
        applyStimulus(8'd12, 8'd18, 8'd0, 1'b1);
        n = 0;
        for (int c = 0; c < 60; c++) begin
            if (!res_valid_o) begin
                step();
                if (gcd_enable_o) n++;
            end
        end
        checkOutput("to_busy_cycles", n, 8);
        checkOutput("to_err", int'(res_err_o), 1);
        checkOutput("to_data", int'(res_data_o), 0);
        kill_done   = 1'b0;
        res_ready_i = 1'b1;
        applyStimulus(8'd12, 8'd18, 8'd6, 1'b0);
        waitDrain(100);
`endif

        checkOutput("sb_leftover", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
